// File: rtl/asic_st_pkg.sv
// rtl/asic_st_pkg.sv - shared constants, types and helpers for the ASIC result packetiser
package asic_st_pkg;

  // Bit positions inside the 32-bit beat word
  localparam int TREADY_BIT = 29;
  localparam int START_BIT  = 27;
  localparam int KSHIFT_BIT = 26;
  localparam int BITOUT_BIT = 24;
  localparam int TOUT_LSB   = 16;
  localparam int ERR_LSB    = 0;

  localparam int TOUT_W = 7;
  localparam int ERR_W  = 7;
  localparam logic [ERR_W-1:0] ERR_MAX = 7'd127;

  // Write-side framing state
  typedef enum logic {
    HUNT   = 1'b0,
    IN_PKT = 1'b1
  } tx_state_e;

  // One FIFO entry: delimiters plus the packed beat word
  typedef struct packed {
    logic        eop;
    logic        sop;
    logic [31:0] data;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);

  // Assemble a beat word; unused bit positions stay zero
  function automatic logic [31:0] pack_word(
    input logic              testready,
    input logic              start,
    input logic              keepshift,
    input logic              bitout,
    input logic [TOUT_W-1:0] tout,
    input logic [ERR_W-1:0]  err
  );
    logic [31:0] w;
    w                       = '0;
    w[TREADY_BIT]           = testready;
    w[START_BIT]            = start;
    w[KSHIFT_BIT]           = keepshift;
    w[BITOUT_BIT]           = bitout;
    w[TOUT_LSB +: TOUT_W]   = tout;
    w[ERR_LSB +: ERR_W]     = err;
    return w;
  endfunction

  // Error accumulator step that sticks at its maximum instead of wrapping
  function automatic logic [ERR_W-1:0] err_sat_inc(
    input logic [ERR_W-1:0] acc,
    input logic             inc
  );
    if (inc && (acc != ERR_MAX)) begin
      return acc + 7'd1;
    end
    return acc;
  endfunction

endpackage

// File: rtl/asic_st_fifo.sv
// rtl/asic_st_fifo.sv - synchronous beat FIFO with full/empty flags
module asic_st_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_req,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_wr;
  logic             do_rd;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_rd   = rd_en && !empty;
  // A pop frees the head slot in the same cycle, so a full FIFO still takes the write
  assign do_wr   = wr_req && (!full || do_rd);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // Advance pointers on accepted writes and pops
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // Pointer registers; clearing them on reset discards all stored beats
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are only observable through valid pointers
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/asic_st_result_tx.sv
// rtl/asic_st_result_tx.sv - frames ASIC result samples into fixed-length streaming packets
module asic_st_result_tx
  import asic_st_pkg::*;
#(
  parameter int PKT_LEN    = 202,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        smp_valid,
  input  logic [6:0]  smp_tout,
  input  logic        smp_bitout,
  input  logic        smp_keepshift,
  input  logic        smp_start,
  input  logic        smp_testready,
  input  logic        ovf_clear,
  output logic [31:0] src_data,
  output logic        src_valid,
  input  logic        src_ready,
  output logic        src_sop,
  output logic        src_eop,
  output logic        ovf
);

  localparam int CW = $clog2(PKT_LEN);
  localparam logic [CW-1:0] LAST_IDX = CW'(PKT_LEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  tx_state_e        state_q, state_d;
  logic [CW-1:0]    beat_cnt_q, beat_cnt_d;
  logic [ERR_W-1:0] err_acc_q, err_acc_d;
  logic             ovf_q, ovf_d;

  logic             wr_req;
  logic             wr_ok;
  beat_t            wr_beat;
  logic [ERR_W-1:0] err_next;
  logic             is_last;

  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [BEAT_W-1:0] fifo_rd_data;
  beat_t            head;

  assign pop   = src_valid && src_ready;
  // The slot is available if there is room or the head leaves this very cycle
  assign wr_ok = !fifo_full || pop;

  // Framing FSM, beat/error counters, word packing and overflow sticky
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    err_acc_d  = err_acc_q;
    ovf_d      = ovf_q;
    wr_req     = 1'b0;
    wr_beat    = '0;
    err_next   = err_sat_inc(err_acc_q, smp_keepshift & smp_bitout);
    is_last    = (beat_cnt_q == LAST_IDX);

    if (smp_valid) begin
      case (state_q)
        HUNT: begin
          // Only a start marker opens a packet; its own error bit is never counted
          if (smp_start) begin
            wr_req       = 1'b1;
            wr_beat.sop  = 1'b1;
            wr_beat.data = pack_word(smp_testready, smp_start, smp_keepshift,
                                     smp_bitout, smp_tout, '0);
            if (wr_ok) begin
              err_acc_d  = '0;
              beat_cnt_d = CNT_ONE;
              state_d    = IN_PKT;
            end
          end
        end
        IN_PKT: begin
          wr_req       = 1'b1;
          wr_beat.eop  = is_last;
          wr_beat.data = pack_word(smp_testready, smp_start, smp_keepshift,
                                   smp_bitout, smp_tout, err_next);
          // Dropped samples leave the counters alone so packet length stays fixed
          if (wr_ok) begin
            err_acc_d = err_next;
            if (is_last) begin
              beat_cnt_d = '0;
              state_d    = HUNT;
            end else begin
              beat_cnt_d = beat_cnt_q + CNT_ONE;
            end
          end
        end
        default: ;
      endcase
    end

    if (ovf_clear) ovf_d = 1'b0;
    // A drop in the same cycle as a clear must still be reported
    if (wr_req && !wr_ok) ovf_d = 1'b1;
  end

  // Write-side state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= HUNT;
      beat_cnt_q <= '0;
      err_acc_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      err_acc_q  <= err_acc_d;
      ovf_q      <= ovf_d;
    end
  end

  asic_st_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_req  (wr_req),
    .wr_data (wr_beat),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign head = beat_t'(fifo_rd_data);

  // Head entry is presented only while valid so idle outputs read as zero
  assign src_valid = !fifo_empty;
  assign src_data  = fifo_empty ? 32'd0 : head.data;
  assign src_sop   = !fifo_empty && head.sop;
  assign src_eop   = !fifo_empty && head.eop;
  assign ovf       = ovf_q;

endmodule

// File: doc/asic_st_result_tx.md
# asic_st_result_tx

Avalon-ST source that packs per-sample results from the turbo-decoder ASIC (Tout, bitout, keepshift, start, testready) into fixed-length packets for the sink side of the test fabric. It sits on the return path beside the input-side packet receiver. It hunts for a frame start, frames PKT_LEN beats with sop/eop and keeps a running bit-error count. It buffers samples in a FIFO so ready backpressure never stalls the ASIC.

## Interface
- PKT_LEN, 202, beats per packet (>=2)
- FIFO_DEPTH, 16, buffer entries (power of 2, >=4)
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-high
- smp_valid  in  1  one ASIC result sample this cycle; no backpressure toward ASIC
- smp_tout  in  7  ASIC Tout
- smp_bitout  in  1  decoded-bit mismatch flag
- smp_keepshift  in  1  sample is a counted data bit
- smp_start  in  1  ASIC start marker
- smp_testready  in  1  ASIC TestReady
- ovf_clear  in  1  clears overflow sticky
- src_data  out  32  beat word
- src_valid  out  1  beat available
- src_ready  in  1  sink accepts (readyLatency 0)
- src_sop / src_eop  out  1 each  packet delimiters
- ovf  out  1  sticky: a sample was dropped on full FIFO

## Operation
- Beat word: [29] testready, [27] start, [26] keepshift, [24] bitout, [22:16] tout, [6:0] err count; all other bits 0.
- Write-side FSM, two states:
  - HUNT (reset state): samples with smp_start=0 are discarded. A sample with smp_start=1 is written as the sop beat: err field 0, err_acc cleared, beat_cnt=1, next state IN_PKT.
  - IN_PKT: each accepted sample is written with beat_cnt incremented. smp_start=1 here is plain data.
- err_acc in IN_PKT: add 1 when keepshift & bitout. Saturate at 127. Each beat carries err_acc including its own contribution. The sop beat is never counted.
- Beat with beat_cnt==PKT_LEN-1 is written with eop=1 and returns FSM to HUNT.
- Overflow: a sample arriving when the FIFO is full and not popped that cycle is dropped. Set ovf. beat_cnt, err_acc and FSM state are unchanged, so packets stay PKT_LEN beats long.
- A dropped sample in HUNT with start=1 leaves the FSM in HUNT.
- ovf_clear clears ovf. If ovf_clear and a new drop occur in the same cycle, the drop wins (ovf=1).
- Read side: src_valid = FIFO non-empty. The head entry drives src_data/sop/eop. A pop occurs on src_valid & src_ready. Head data is held stable while src_ready=0.

## Timing
- Reset values: src_valid 0, src_data 0, src_sop 0, src_eop 0, ovf 0, FSM HUNT, beat_cnt 0, err_acc 0, FIFO empty.
- Latency: a sample written at edge N is visible as src_valid after edge N, i.e. 1 cycle to first beat.
- Throughput: 1 beat/cycle with src_ready=1.
- Full FIFO with a simultaneous pop: the write is accepted and there is no overflow.
- Empty FIFO with a simultaneous write: src_valid rises next cycle with no bypass.
- Reset mid-packet discards FIFO contents and any partial packet; the sink sees no eop for it.
- ovf asserts the cycle after the dropping edge.

## Structure
- Package asic_st_pkg:
  - bit-position constants (TREADY_BIT=29, START_BIT=27, KSHIFT_BIT=26, BITOUT_BIT=24, TOUT_LSB=16, ERR_LSB=0)
  - FSM enum {HUNT, IN_PKT}
  - beat struct {eop, sop, data[31:0]}
- Sub-module asic_st_fifo: synchronous FIFO.
  - Width 34, depth FIFO_DEPTH.
  - Outputs full/empty.
  - Write accepted when not full or popping in the same cycle.
- Top holds the FSM, counters, word packing and overflow logic.

## Test plan
- PKT_LEN=8, src_ready=1: 3 start=0 samples, then start=1 followed by 7 samples with keepshift&bitout on samples 2 and 5 -> exactly 8 beats. sop on beat 0, eop on beat 7. Err fields 0,0,1,1,1,2,2,2. ovf=0.
- Same stimulus with src_ready random ~50% -> identical beat sequence, data stable while stalled, no drops with FIFO_DEPTH=16.
- src_ready=0, 20 consecutive samples after start -> first 16 stored, ovf=1, beat_cnt=16. After src_ready=1 the packet still ends after exactly PKT_LEN accepted samples. ovf_clear drops ovf to 0.
- PKT_LEN=202, every beat keepshift&bitout=1 -> err field counts 1..127 and then holds 127 through eop.
- Assert reset at beat 4 of a packet -> all outputs 0 next cycle. The next packet begins only at a new start=1 sample, with err field 0.
- Two back-to-back packets with a start sample immediately after eop -> second sop directly follows first eop beat with no gap at src_ready=1.
